// File: rtl/crc_pkg.sv
// crc_pkg: shared definitions for the serial CRC generator family.
//
// Contents:
//   - FSM state encoding (ST_IDLE / ST_SHIFT / ST_OUT) and the enum built on it.
//   - Default CRC-8 constants (right-shift tap mask and seed).
//   - CRC-16-CCITT and CRC-32 presets in reflected (right-shift) form.
//
// Handshake contract for every block using this package:
//   'active' is a level qualifier: each rising clk edge with active=1 carries
//   exactly one data bit. 'valid' is a level qualifier on the serial output:
//   each rising clk edge with valid=1 presents one CRC bit (LSB first).
//   There is no ready/back-pressure; the consumer must accept every valid bit.
package crc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_OUT   = ST_OUT
  } crc_state_e;

  // Default CRC-8 configuration.
  localparam logic [7:0]  CRC8_POLY        = 8'hC4;
  localparam logic [7:0]  CRC8_SEED        = 8'hD8;

  // CRC-16-CCITT (X-25 flavour), reflected polynomial 0x1021 -> 0x8408.
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h8408;
  localparam logic [15:0] CRC16_CCITT_SEED = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_XOR  = 16'hFFFF;

  // CRC-32 (IEEE 802.3), reflected polynomial 0x04C11DB7 -> 0xEDB88320.
  localparam logic [31:0] CRC32_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC32_SEED       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR        = 32'hFFFFFFFF;

endpackage

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step: combinational one-bit step of a right-shifting CRC LFSR.
//
// Ports:
//   lfsr_i  [CRC_W-1:0]  current register value
//   data_i               incoming data bit
//   next_o  [CRC_W-1:0]  register value after absorbing data_i
//
// fb = data ^ lfsr[0]; next = (lfsr >> 1) ^ (fb ? POLY : 0).
// Kept as its own block so a byte-parallel variant can chain eight copies.
module crc_lfsr_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'hC4)
) (
  input  logic [CRC_W-1:0] lfsr_i,
  input  logic             data_i,
  output logic [CRC_W-1:0] next_o
);

  logic fb;

  assign fb     = data_i ^ lfsr_i[0];
  assign next_o = (lfsr_i >> 1) ^ ({CRC_W{fb}} & POLY);

endmodule

// File: rtl/crc_serial_param.sv
// crc_serial_param: parametrised serial CRC generator.
//
// Absorbs a bit stream LSB-first while 'active' is high, then shifts the CRC
// out serially (LSB first) with 'valid' high for exactly CRC_W cycles. The
// final CRC is also presented in parallel on crc_par, updated with a one-cycle
// 'done' strobe that coincides with the first valid cycle.
//
// Optional feature: define CRC_XOROUT_EN to XOR the final register with
// XOR_OUT before it is presented (both crc_par and the serial stream).
// Without the macro XOR_OUT is ignored and no XOR logic exists.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   data         in   serial data bit, sampled while active=1
//   active       in   frame enable; a low sample ends the frame
//   valid        out  high while crc carries a CRC bit
//   crc          out  serial CRC bit, LSB first
//   crc_par      out  [CRC_W] final CRC, held until the next done
//   done         out  one-cycle pulse when the CRC is finalised
//   busy         out  high in SHIFT or OUT
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: one data bit per clk edge with active=1; one CRC bit per clk
// edge with valid=1; no back-pressure in either direction.
module crc_serial_param
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] SEED    = CRC_W'(CRC8_SEED),
  parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             active,
  output logic             valid,
  output logic             crc,
  output logic [CRC_W-1:0] crc_par,
  output logic             done,
  output logic             busy,
  output crc_state_e       dbg_state_o
);

  localparam int               CNT_W    = $clog2(CRC_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CRC_W-1:0] out_sr_q, out_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             crc_q, crc_d;
  logic [CRC_W-1:0] crc_par_q, crc_par_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [CRC_W-1:0] step_src;
  logic [CRC_W-1:0] step_next;
  logic [CRC_W-1:0] fin_w;

  // The first bit of a frame is absorbed on the edge that leaves IDLE, so it
  // must be stepped from SEED rather than whatever the register holds.
  assign step_src = (state_q == S_IDLE) ? SEED : lfsr_q;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .lfsr_i (step_src),
    .data_i (data),
    .next_o (step_next)
  );

`ifdef CRC_XOROUT_EN
  assign fin_w = lfsr_q ^ XOR_OUT;
`else
  assign fin_w = lfsr_q;
  logic unused_xor_out;
  assign unused_xor_out = ^XOR_OUT;
`endif

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    out_sr_d  = out_sr_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    crc_d     = crc_q;
    crc_par_d = crc_par_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        if (active) begin
          lfsr_d  = step_next;
          state_d = S_SHIFT;
          busy_d  = 1'b1;
        end else begin
          lfsr_d  = SEED;
        end
      end

      S_SHIFT: begin
        if (active) begin
          lfsr_d = step_next;
        end else begin
          // Frame ended: publish the CRC and emit bit 0 on the same edge.
          crc_par_d = fin_w;
          done_d    = 1'b1;
          state_d   = S_OUT;
          valid_d   = 1'b1;
          crc_d     = fin_w[0];
          out_sr_d  = fin_w >> 1;
          cnt_d     = CNT_ONE;
        end
      end

      S_OUT: begin
        // 'active' is deliberately ignored here; those bits are dropped.
        if (cnt_q < CNT_LAST) begin
          crc_d    = out_sr_q[0];
          out_sr_d = out_sr_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
        end else begin
          valid_d = 1'b0;
          crc_d   = 1'b0;
          busy_d  = 1'b0;
          lfsr_d  = SEED;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        lfsr_d  = SEED;
        cnt_d   = '0;
        valid_d = 1'b0;
        crc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      out_sr_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      crc_q     <= 1'b0;
      crc_par_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      out_sr_q  <= out_sr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      crc_q     <= crc_d;
      crc_par_q <= crc_par_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign valid       = valid_q;
  assign crc         = crc_q;
  assign crc_par     = crc_par_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc_serial_param.sv
// tb_crc_serial_param: directed, table-driven bench for crc_serial_param.
// Two instances: default CRC-8 (XOR_OUT=8'hFF) and CRC-16/X-25.
// Expected values are hand-computed raw CRCs, XORed with the output mask
// when CRC_XOROUT_EN is defined.
module tb_crc_serial_param;
  import crc_pkg::*;

  localparam int W = 1;

`ifdef CRC_XOROUT_EN
  localparam logic [7:0]  X8  = 8'hFF;
  localparam logic [15:0] X16 = 16'hFFFF;
`else
  localparam logic [7:0]  X8  = 8'h00;
  localparam logic [15:0] X16 = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a8, d8, a16, d16;
  logic v8, c8, dn8, b8;
  logic v16, c16, dn16, b16;
  logic [7:0]  p8;
  logic [15:0] p16;
  crc_state_e  s8, s16;

  crc_serial_param #(
    .CRC_W(8), .POLY(8'hC4), .SEED(8'hD8), .XOR_OUT(8'hFF)
  ) dut8 (
    .clk(clk), .rst(rst), .data(d8), .active(a8),
    .valid(v8), .crc(c8), .crc_par(p8), .done(dn8), .busy(b8),
    .dbg_state_o(s8)
  );

  crc_serial_param #(
    .CRC_W(16), .POLY(16'h8408), .SEED(16'hFFFF), .XOR_OUT(16'hFFFF)
  ) dut16 (
    .clk(clk), .rst(rst), .data(d16), .active(a16),
    .valid(v16), .crc(c16), .crc_par(p16), .done(dn16), .busy(b16),
    .dbg_state_o(s16)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic a, input logic d);
    if (sel == 0) begin
      a8 = a; d8 = d;
    end else begin
      a16 = a; d16 = d;
    end
  endtask

  task automatic get_out(input int sel, output logic v, output logic c, output logic dn,
                         output logic b, output logic [31:0] par);
    if (sel == 0) begin
      v = v8; c = c8; dn = dn8; b = b8; par = {24'b0, p8};
    end else begin
      v = v16; c = c16; dn = dn16; b = b16; par = {16'b0, p16};
    end
  endtask

  // One data bit per edge, LSB first.
  task automatic send_bits(input int sel, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b1, bits[i]);
      tick();
    end
  endtask

  // Ends the frame and checks the whole output phase. act_dur/dat_dur are
  // driven during OUT (and remain driven on return).
  task automatic finish_frame(input int sel, input string tag, input logic [31:0] exp,
                              input int w, input logic act_dur, input logic dat_dur);
    logic v, c, dn, b;
    logic [31:0] par;
    get_out(sel, v, c, dn, b, par);
    check({tag, "_pre_valid"}, v, 0);
    check({tag, "_pre_busy"}, b, 1);
    drive(sel, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < w; k++) exp_q.push_back(exp[k]);
    for (int k = 0; k < w; k++) begin
      get_out(sel, v, c, dn, b, par);
      check($sformatf("%s_valid%0d", tag, k), v, 1);
      check($sformatf("%s_done%0d", tag, k), dn, (k == 0) ? 1 : 0);
      check($sformatf("%s_crc%0d", tag, k), c, exp_q.pop_front());
      if (k == 0) check({tag, "_par"}, par, exp);
      drive(sel, act_dur, dat_dur);
      tick();
    end
    get_out(sel, v, c, dn, b, par);
    check({tag, "_valid_end"}, v, 0);
    check({tag, "_busy_end"}, b, 0);
    check({tag, "_crc_end"}, c, 0);
    check({tag, "_par_hold"}, par, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [31:0] bits;
    logic [7:0]  raw;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] msg[9];

  initial begin
    vecs[0] = '{n: 8, bits: 32'h00, raw: 8'h14};
    vecs[1] = '{n: 1, bits: 32'h01, raw: 8'hA8};
    vecs[2] = '{n: 2, bits: 32'h01, raw: 8'h54};
    vecs[3] = '{n: 8, bits: 32'hFF, raw: 8'h72};
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    rst = 1'b1;
    a8 = 0; d8 = 0; a16 = 0; d16 = 0;
    #2;
    check("rst_valid", v8, 0);
    check("rst_crc", c8, 0);
    check("rst_done", dn8, 0);
    check("rst_par", p8, 0);
    check("rst_busy", b8, 0);
    check("rst_state", s8, S_IDLE);
    check("rst_par16", p16, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames on the CRC-8 instance.
    for (int i = 0; i < 4; i++) begin
      send_bits(0, vecs[i].bits, vecs[i].n);
      finish_frame(0, $sformatf("vec%0d", i), {24'b0, vecs[i].raw ^ X8}, 8, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_idle_hold", i), p8, vecs[i].raw ^ X8);
      check($sformatf("vec%0d_idle_state", i), s8, S_IDLE);
    end

    // Back-to-back: active held high (data=1) through OUT; those bits are
    // dropped and the next frame (a single 1) starts on the edge after IDLE.
    send_bits(0, 32'h00, 8);
    finish_frame(0, "b2b1", {24'b0, 8'h14 ^ X8}, 8, 1'b1, 1'b1);
    check("b2b_idle_state", s8, S_IDLE);
    tick();
    check("b2b_restart_busy", b8, 1);
    finish_frame(0, "b2b2", {24'b0, 8'hA8 ^ X8}, 8, 1'b0, 1'b0);

    // Reset mid-OUT after three valid cycles: outputs drop without a clock.
    send_bits(0, 32'h00, 8);
    drive(0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("pre_rst_valid", v8, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", v8, 0);
    check("mid_rst_crc", c8, 0);
    check("mid_rst_busy", b8, 0);
    check("mid_rst_done", dn8, 0);
    check("mid_rst_par", p8, 0);
    check("mid_rst_state", s8, S_IDLE);
    #3;
    rst = 1'b0;
    send_bits(0, 32'h00, 8);
    finish_frame(0, "post_rst", {24'b0, 8'h14 ^ X8}, 8, 1'b0, 1'b0);

    // CRC-16/X-25 over ASCII "123456789".
    for (int i = 0; i < 9; i++) send_bits(1, {24'b0, msg[i]}, 8);
    finish_frame(1, "x25", {16'b0, 16'h6F91 ^ X16}, 16, 1'b0, 1'b0);
    check("x25_crc8_untouched", b8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
